equiv_check_sequencer: RTL and testbench
========================================

Name: equiv_check_sequencer

Overview:
Synthesizable sequencer that drives a golden model and its post-route netlist with a shared pseudo-random stimulus word and compares their outputs. Each run holds both DUTs in reset, applies NUM_VECTORS LFSR vectors with a settle window, and counts mismatches. It reports pass/fail and the index of the first failing vector. It sits between the equivalence harness top and the two DUT instances, and replaces the hand-written stimulus/compare loop.

Parameters:
WIDTH, 32, stimulus and DUT output width (2..32)
NUM_VECTORS, 1000, vectors per run (1..65535)
RST_CYCLES, 2, cycles dut_rst is held high at run start (>=1)
SETTLE_CYCLES, 2, wait cycles between stimulus update and compare (>=1)
SEED, 32'h1, LFSR seed; a value of 0 is replaced by 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled in IDLE or DONE
golden_out  in  WIDTH  golden DUT output
netlist_out  in  WIDTH  netlist DUT output
dut_rst  out  1  reset driven to both DUTs
stim_out  out  WIDTH  stimulus driven to both DUTs
busy  out  1  run in progress
done  out  1  run complete; held until next start
pass  out  1  done and mismatch_count==0
mismatch_count  out  16  saturating mismatch count
first_fail_valid  out  1  at least one mismatch this run
first_fail_index  out  16  vector index of the first mismatch

Behaviour:
- Reset (any state, any cycle): state=IDLE, dut_rst=1, stim_out=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_valid=0, first_fail_index=0, LFSR=SEED, vec_idx=0. This aborts a run in progress with no done pulse.
- States: IDLE, RST, RELEASE, APPLY, WAIT, COMPARE, DONE.
- IDLE: dut_rst=1. When start=1, go to RST. On that edge, clear the counters, first_fail_*, done and pass, load LFSR=SEED, and set vec_idx=0.
- RST: dut_rst=1 and stim_out=0 for RST_CYCLES cycles, then go to RELEASE.
- RELEASE: dut_rst=0 for 1 cycle, then go to APPLY.
- Entering APPLY: stim_out <= LFSR[WIDTH-1:0]; the LFSR advances one step on the same edge.
- APPLY lasts 1 cycle, then WAIT.
- WAIT lasts SETTLE_CYCLES cycles, then COMPARE.
- COMPARE (1 cycle): if golden_out != netlist_out, increment mismatch_count, saturating at 16'hFFFF.
- On the first mismatch of a run, set first_fail_valid=1 and first_fail_index=vec_idx.
- From COMPARE: if vec_idx==NUM_VECTORS-1, go to DONE; otherwise increment vec_idx and go to APPLY.
- Vector period is SETTLE_CYCLES+2 cycles. stim_out is stable from APPLY through COMPARE.
- DONE: done=1, pass=(mismatch_count==0), stim_out holds its last value, dut_rst=0. start=1 restarts exactly as from IDLE, so the sequence repeats from SEED.
- busy=1 in RST, RELEASE, APPLY, WAIT and COMPARE; start is ignored while busy=1.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). Step: lsb=L[0]; L=L>>1; if lsb then L^=mask. Vector 0 = SEED, vector 1 = one step after SEED.
- All outputs are registered. No combinational path from golden_out/netlist_out to any output.
- Timing (start sampled at edge E0, RST_CYCLES=2, SETTLE_CYCLES=2):
  - dut_rst falls at E2.
  - Vector k is applied at E3+4k and compared in the cycle after E3+4k+3.
  - DONE is entered, and done rises, at E3+4*NUM_VECTORS.

Test Plan:
- NUM_VECTORS=4, netlist_out tied to golden_out, start pulse at E0 -> dut_rst falls at E2, stim_out=32'h1 at E3, done=1 and pass=1 at E19, mismatch_count=0, first_fail_valid=0.
- NUM_VECTORS=1000, netlist_out=golden_out^1 only while vec_idx==2 -> done with pass=0, mismatch_count=1, first_fail_valid=1, first_fail_index=2.
- NUM_VECTORS=1000, netlist_out=~golden_out always -> mismatch_count=1000, first_fail_index=0; with mismatch_count preloaded via force to 16'hFFFE, the count saturates at 16'hFFFF.
- rst asserted mid-WAIT of vector 5 -> next cycle: state IDLE, busy=0, done=0, dut_rst=1, stim_out=0, counters 0; a following start reproduces stim_out=SEED first.
- start held high for the entire run -> exactly one run; busy stays 1 throughout; from DONE, start=1 restarts with counters cleared and an identical stim_out sequence (check the first 3 words against the reference LFSR model).
- SEED=0 parameter -> first stim_out=32'h1; WIDTH=8 -> stim_out is LFSR[7:0] and the comparison covers 8 bits only.

Source files
------------

// File: rtl/equiv_check_sequencer.sv
// Equivalence-check sequencer: drives a shared LFSR stimulus word into a golden model
// and its post-route netlist, then counts output mismatches over NUM_VECTORS vectors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, DUTs held in reset
// S_RST     | DUT reset held for RST_CYCLES cycles, stimulus zeroed
// S_RELEASE | DUT reset released, one cycle before the first vector
// S_APPLY   | new stimulus word presented (one cycle)
// S_WAIT    | settle window of SETTLE_CYCLES cycles
// S_COMPARE | golden_out vs netlist_out sampled (one cycle)
// S_DONE    | results held until the next start

module equiv_check_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned NUM_VECTORS   = 1000,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] golden_out,
  input  logic [WIDTH-1:0] netlist_out,
  output logic             dut_rst,
  output logic [WIDTH-1:0] stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic             first_fail_valid,
  output logic [15:0]      first_fail_index
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int unsigned TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_RELEASE, S_APPLY, S_WAIT, S_COMPARE, S_DONE
  } state_t;

  state_t         state, state_next;
  logic [TW-1:0]  timer;
  logic [15:0]    vec_idx;
  logic [31:0]    lfsr;
  logic [15:0]    count_next;
  logic           start_run;
  logic           mismatch;
  logic           last_vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign mismatch  = (state == S_COMPARE) && (golden_out != netlist_out);
  assign last_vec  = (vec_idx == 16'(NUM_VECTORS - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = S_RST;
      S_RST:          if (timer == '0) state_next = S_RELEASE;
      S_RELEASE:      state_next = S_APPLY;
      S_APPLY:        state_next = S_WAIT;
      S_WAIT:         if (timer == '0) state_next = S_COMPARE;
      S_COMPARE:      state_next = last_vec ? S_DONE : S_APPLY;
      default:        state_next = S_IDLE;
    endcase
  end

  // pass is registered on the same edge as the final compare, so it needs the updated count
  always_comb begin
    count_next = mismatch_count;
    if (start_run)
      count_next = '0;
    else if (mismatch && (mismatch_count != 16'hFFFF))
      count_next = mismatch_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      timer            <= '0;
      vec_idx          <= '0;
      lfsr             <= SEED_EFF;
      dut_rst          <= 1'b1;
      stim_out         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_index <= '0;
    end else begin
      state          <= state_next;
      mismatch_count <= count_next;
      dut_rst        <= (state_next == S_IDLE) || (state_next == S_RST);
      busy           <= state_next inside {S_RST, S_RELEASE, S_APPLY, S_WAIT, S_COMPARE};
      done           <= (state_next == S_DONE);
      pass           <= (state_next == S_DONE) && (count_next == 16'h0);

      if (start_run)
        timer <= TW'(RST_CYCLES - 1);
      else if (state == S_APPLY)
        timer <= TW'(SETTLE_CYCLES - 1);
      else if (timer != '0)
        timer <= timer - 1'b1;

      if (start_run) begin
        vec_idx  <= '0;
        lfsr     <= SEED_EFF;
        stim_out <= '0;
      end else begin
        if (state_next == S_APPLY) begin
          stim_out <= lfsr[WIDTH-1:0];
          lfsr     <= lfsr_step(lfsr);
        end
        if ((state == S_COMPARE) && !last_vec)
          vec_idx <= vec_idx + 16'd1;
      end

      if (start_run) begin
        first_fail_valid <= 1'b0;
        first_fail_index <= '0;
      end else if (mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_index <= vec_idx;
      end
    end
  end

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Bench for equiv_check_sequencer: a 4-vector 32-bit instance checked from a timing table,
// and an 8-bit 1000-vector instance with SEED=0 checked against a reference model.

module tb_equiv_check_sequencer;

  localparam int A_N   = 4;
  localparam int B_W   = 8;
  localparam int B_N   = 1000;
  localparam int B_RST = 3;
  localparam int B_SET = 3;
  localparam int B_P   = B_SET + 2;
  localparam int B_END = B_RST + 1 + B_N * B_P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_rst, a_start, a_dut_rst, a_busy, a_done, a_pass, a_ffv;
  logic [31:0] a_golden, a_netlist, a_stim, a_err;
  logic [15:0] a_cnt, a_ffi;

  logic           b_rst, b_start, b_dut_rst, b_busy, b_done, b_pass, b_ffv;
  logic [B_W-1:0] b_golden, b_netlist, b_stim, b_err;
  logic [15:0]    b_cnt, b_ffi;

  assign a_golden  = {a_stim[15:0], a_stim[31:16]} ^ 32'h1234_5678;
  assign a_netlist = a_golden ^ a_err;
  assign b_golden  = {b_stim[3:0], b_stim[7:4]} ^ 8'hC3;
  assign b_netlist = b_golden ^ b_err;

  equiv_check_sequencer #(
    .WIDTH(32), .NUM_VECTORS(A_N), .RST_CYCLES(2), .SETTLE_CYCLES(2), .SEED(32'h1)
  ) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start),
    .golden_out(a_golden), .netlist_out(a_netlist),
    .dut_rst(a_dut_rst), .stim_out(a_stim), .busy(a_busy), .done(a_done), .pass(a_pass),
    .mismatch_count(a_cnt), .first_fail_valid(a_ffv), .first_fail_index(a_ffi)
  );

  equiv_check_sequencer #(
    .WIDTH(B_W), .NUM_VECTORS(B_N), .RST_CYCLES(B_RST), .SETTLE_CYCLES(B_SET), .SEED(32'h0)
  ) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start),
    .golden_out(b_golden), .netlist_out(b_netlist),
    .dut_rst(b_dut_rst), .stim_out(b_stim), .busy(b_busy), .done(b_done), .pass(b_pass),
    .mismatch_count(b_cnt), .first_fail_valid(b_ffv), .first_fail_index(b_ffi)
  );

  // Reference stimulus sequence: Galois LFSR x^32+x^22+x^2+x+1 starting from 1
  logic [31:0] vec[B_N];
  logic [7:0]  b_errs[B_N];

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic        dut_rst;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] stim;
  } row_t;

  row_t tbl[$];

  // One full run of instance B; b_errs[k] is XORed into netlist_out while vector k is live
  task automatic run_b(input string tag, input bit do_force);
    int  exp_cnt = 0;
    int  exp_ffi = 0;
    bit  exp_ffv = 0;
    int  k;
    for (int i = 0; i < B_N; i++) begin
      if (do_force && i == 500) exp_cnt = 16'hFFFE;
      if (b_errs[i] != 8'h0) begin
        if (!exp_ffv) begin exp_ffv = 1; exp_ffi = i; end
        exp_cnt++;
      end
    end
    if (exp_cnt > 65535) exp_cnt = 65535;

    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int n = 0; n <= B_END; n++) begin
      k = (n >= B_RST + 1) ? (n - B_RST - 1) / B_P : -1;
      b_err = (k >= 0 && k < B_N) ? b_errs[k] : 8'h0;
      if (n == B_RST - 1) chk({tag, " dut_rst held"}, b_dut_rst, 1);
      if (n == B_RST)     chk({tag, " dut_rst released"}, b_dut_rst, 0);
      if (k >= 0 && k < B_N && ((n - B_RST - 1) % B_P) == 0) begin
        chk($sformatf("%s stim[%0d]", tag, k), b_stim, vec[k][7:0]);
        chk($sformatf("%s busy[%0d]", tag, k), b_busy, 1);
        if (do_force && k == 500) force dut_b.mismatch_count = 16'hFFFE;
      end
      if (do_force && k == 500 && ((n - B_RST - 1) % B_P) == 1) release dut_b.mismatch_count;
      if (n == B_END - 1) chk({tag, " done early"}, b_done, 0);
      if (n == B_END) begin
        chk({tag, " done"}, b_done, 1);
        chk({tag, " busy end"}, b_busy, 0);
        chk({tag, " pass"}, b_pass, (exp_cnt == 0));
        chk({tag, " mismatch_count"}, b_cnt, exp_cnt);
        chk({tag, " first_fail_valid"}, b_ffv, exp_ffv);
        chk({tag, " first_fail_index"}, b_ffi, exp_ffi);
      end
      @(negedge clk);
    end
    b_err = 8'h0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " a dut_rst"}, a_dut_rst, 1);
    chk({tag, " a stim"}, a_stim, 0);
    chk({tag, " a busy"}, a_busy, 0);
    chk({tag, " a done"}, a_done, 0);
    chk({tag, " a pass"}, a_pass, 0);
    chk({tag, " a count"}, a_cnt, 0);
    chk({tag, " a ffv"}, a_ffv, 0);
    chk({tag, " a ffi"}, a_ffi, 0);
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, " b dut_rst"}, b_dut_rst, 1);
    chk({tag, " b stim"}, b_stim, 0);
    chk({tag, " b busy"}, b_busy, 0);
    chk({tag, " b done"}, b_done, 0);
    chk({tag, " b pass"}, b_pass, 0);
    chk({tag, " b count"}, b_cnt, 0);
    chk({tag, " b ffv"}, b_ffv, 0);
    chk({tag, " b ffi"}, b_ffi, 0);
  endtask

  initial begin
    int ti;
    vec[0] = 32'h1;
    for (int i = 1; i < B_N; i++) vec[i] = lfsr_next(vec[i-1]);

    //          n  rst busy done pass stim
    tbl.push_back('{0,  1, 1, 0, 0, 32'h0});
    tbl.push_back('{1,  1, 1, 0, 0, 32'h0});
    tbl.push_back('{2,  0, 1, 0, 0, 32'h0});
    tbl.push_back('{3,  0, 1, 0, 0, 32'h1});
    tbl.push_back('{6,  0, 1, 0, 0, 32'h1});
    tbl.push_back('{7,  0, 1, 0, 0, 32'h8020_0003});
    tbl.push_back('{11, 0, 1, 0, 0, 32'hC030_0002});
    tbl.push_back('{15, 0, 1, 0, 0, 32'h6018_0001});
    tbl.push_back('{18, 0, 1, 0, 0, 32'h6018_0001});
    tbl.push_back('{19, 0, 0, 1, 1, 32'h6018_0001});
    tbl.push_back('{22, 0, 0, 1, 1, 32'h6018_0001});

    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_err = 32'h0; b_err = 8'h0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk_reset_b("reset");
    a_rst = 1'b0; b_rst = 1'b0;

    // Instance A: timing table with matching DUTs
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    ti = 0;
    for (int n = 0; n <= 22; n++) begin
      while (ti < tbl.size() && tbl[ti].n == n) begin
        chk($sformatf("tbl n=%0d dut_rst", n), a_dut_rst, tbl[ti].dut_rst);
        chk($sformatf("tbl n=%0d busy", n), a_busy, tbl[ti].busy);
        chk($sformatf("tbl n=%0d done", n), a_done, tbl[ti].done);
        chk($sformatf("tbl n=%0d pass", n), a_pass, tbl[ti].pass);
        chk($sformatf("tbl n=%0d stim", n), a_stim, tbl[ti].stim);
        ti++;
      end
      @(negedge clk);
    end
    chk("tbl count", a_cnt, 0);
    chk("tbl ffv", a_ffv, 0);

    // Instance A: start held high through a failing run, then restart from DONE
    a_err = 32'h0000_0100;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 19; n++) begin
      chk($sformatf("held busy n=%0d", n), a_busy, 1);
      @(negedge clk);
    end
    chk("held done", a_done, 1);
    chk("held pass", a_pass, 0);
    chk("held count", a_cnt, A_N);
    chk("held ffv", a_ffv, 1);
    chk("held ffi", a_ffi, 0);
    a_err = 32'h0;
    @(negedge clk);
    a_start = 1'b0;
    chk("restart busy", a_busy, 1);
    chk("restart done", a_done, 0);
    chk("restart count", a_cnt, 0);
    chk("restart ffv", a_ffv, 0);
    chk("restart pass", a_pass, 0);
    for (int n = 21; n <= 39; n++) begin
      @(negedge clk);
      if (n == 23) chk("restart stim0", a_stim, vec[0]);
      if (n == 27) chk("restart stim1", a_stim, vec[1]);
      if (n == 31) chk("restart stim2", a_stim, vec[2]);
      if (n == 39) begin
        chk("restart done end", a_done, 1);
        chk("restart pass end", a_pass, 1);
      end
    end

    // Instance B: directed mismatch patterns
    for (int i = 0; i < B_N; i++) b_errs[i] = 8'h0;
    run_b("clean", 1'b0);
    b_errs[2] = 8'h01;
    run_b("vec2", 1'b0);
    for (int i = 0; i < B_N; i++) b_errs[i] = 8'hFF;
    run_b("all", 1'b0);
    run_b("sat", 1'b1);

    // Instance B: reset in the middle of vector 5's settle window
    for (int i = 0; i < B_N; i++) b_errs[i] = 8'h0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int n = 0; n < B_RST + 1 + 5 * B_P + 2; n++) begin
      b_err = (n >= B_RST + 1) ? 8'h80 : 8'h0;
      @(negedge clk);
    end
    chk("abort pre count", b_cnt, 5);
    chk("abort pre busy", b_busy, 1);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_err = 8'h0;
    chk_reset_b("abort");

    // Instance B: randomized mismatch patterns
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < B_N; i++)
        b_errs[i] = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
      run_b($sformatf("rand%0d", r), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
